// File: rtl/mem_access_ctrl.sv
// Memory access controller between the SLC-3 core memory port and a synchronous BRAM.
// Each level-held OE/WE strobe becomes one registered BRAM access, and a one-cycle Mem_Ready pulse reports completion.
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_Ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, DONE, HOLD} state_t;

  localparam logic [2:0] RD_CNT = 3'(RD_LAT);
  localparam logic [2:0] WR_CNT = 3'(WR_LAT);

  state_t            r_state, w_state_nx;
  logic [2:0]        r_cnt, w_cnt_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic              r_rdy, w_rdy_nx;
  logic [ADDR_W-1:0] r_baddr, w_baddr_nx;
  logic              r_ben, w_ben_nx;
  logic              r_bwe, w_bwe_nx;
  logic [DATA_W-1:0] r_bdin, w_bdin_nx;
  logic              w_strobes_low;

  assign w_strobes_low = ~OE & ~WE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_rdy   <= 1'b0;
      r_baddr <= '0;
      r_ben   <= 1'b0;
      r_bwe   <= 1'b0;
      r_bdin  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_rdata <= w_rdata_nx;
      r_rdy   <= w_rdy_nx;
      r_baddr <= w_baddr_nx;
      r_ben   <= w_ben_nx;
      r_bwe   <= w_bwe_nx;
      r_bdin  <= w_bdin_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rdata_nx = r_rdata;
    w_rdy_nx   = 1'b0;
    w_baddr_nx = r_baddr;
    w_ben_nx   = 1'b0;
    w_bwe_nx   = 1'b0;
    w_bdin_nx  = r_bdin;
    unique case (r_state)
      IDLE: begin
        if (WE) begin
          w_baddr_nx = ADDR;
          w_bdin_nx  = Data_to_SRAM;
          w_ben_nx   = 1'b1;
          w_bwe_nx   = 1'b1;
          w_cnt_nx   = WR_CNT;
          w_state_nx = WR_WAIT;
        end else if (OE) begin
          w_baddr_nx = ADDR;
          w_ben_nx   = 1'b1;
          w_cnt_nx   = RD_CNT;
          w_state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_rdata_nx = bram_dout;
          w_rdy_nx   = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = DONE;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      // Finishing on zero rather than one gives WR_LAT extra cycles after the write edge, including when WR_LAT is 0.
      WR_WAIT: begin
        if (r_cnt == '0) begin
          w_rdy_nx   = 1'b1;
          w_state_nx = DONE;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      DONE:    w_state_nx = w_strobes_low ? IDLE : HOLD;
      HOLD:    if (w_strobes_low) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign Data_from_SRAM = r_rdata;
  assign Mem_Ready      = r_rdy;
  assign bram_addr      = r_baddr;
  assign bram_en        = r_ben;
  assign bram_we        = r_bwe;
  assign bram_din       = r_bdin;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: two instances (RD_LAT=2/WR_LAT=1 and RD_LAT=1/WR_LAT=0),
// each behind a simple BRAM, checked cycle by cycle against an access-level reference model.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] addr [2];
  logic [15:0] dto  [2];
  logic        oe   [2];
  logic        we   [2];

  logic [15:0] dfrom0, dfrom1, baddr0, baddr1, bdin0, bdin1, bdout0, bdout1;
  logic        rdy0, rdy1, ben0, ben1, bwe0, bwe1;

  logic [15:0] dfrom [2];
  logic [15:0] baddr [2];
  logic [15:0] bdin  [2];
  logic        rdy   [2];
  logic        ben   [2];
  logic        bwe   [2];

  logic [15:0] mem0 [65536];
  logic [15:0] mem1 [65536];
  logic        pl_en [2];
  logic [15:0] pl_addr, pl_data;

  logic [15:0] ref0 [int];
  logic [15:0] ref1 [int];
  logic [15:0] last_rd [2];

  int n_cmp, n_bad;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2), .WR_LAT(1)) dut0 (
    .Clk(Clk), .Reset(Reset), .ADDR(addr[0]), .OE(oe[0]), .WE(we[0]),
    .Data_to_SRAM(dto[0]), .Data_from_SRAM(dfrom0), .Mem_Ready(rdy0),
    .bram_addr(baddr0), .bram_en(ben0), .bram_we(bwe0), .bram_din(bdin0),
    .bram_dout(bdout0)
  );

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .WR_LAT(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .ADDR(addr[1]), .OE(oe[1]), .WE(we[1]),
    .Data_to_SRAM(dto[1]), .Data_from_SRAM(dfrom1), .Mem_Ready(rdy1),
    .bram_addr(baddr1), .bram_en(ben1), .bram_we(bwe1), .bram_din(bdin1),
    .bram_dout(bdout1)
  );

  always_comb begin
    dfrom[0] = dfrom0; dfrom[1] = dfrom1;
    baddr[0] = baddr0; baddr[1] = baddr1;
    bdin[0]  = bdin0;  bdin[1]  = bdin1;
    rdy[0]   = rdy0;   rdy[1]   = rdy1;
    ben[0]   = ben0;   ben[1]   = ben1;
    bwe[0]   = bwe0;   bwe[1]   = bwe1;
  end

  // BRAM models: writes take effect at the edge that samples bram_en, and reads follow bram_addr.
  always @(posedge Clk) begin
    if (pl_en[0]) mem0[pl_addr] <= pl_data;
    else if (ben0 && bwe0) mem0[baddr0] <= bdin0;
  end
  always @(posedge Clk) begin
    if (pl_en[1]) mem1[pl_addr] <= pl_data;
    else if (ben1 && bwe1) mem1[baddr1] <= bdin1;
  end
  assign bdout0 = mem0[baddr0];
  assign bdout1 = mem1[baddr1];

  function automatic int rd_lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int wr_lat(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] ref_rd(input int i, input logic [15:0] a);
    if (i == 0) return ref0.exists(int'(a)) ? ref0[int'(a)] : 16'h0000;
    return ref1.exists(int'(a)) ? ref1[int'(a)] : 16'h0000;
  endfunction

  task automatic ref_wr(input int i, input logic [15:0] a, input logic [15:0] d);
    if (i == 0) ref0[int'(a)] = d;
    else ref1[int'(a)] = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_addr = a; pl_data = d; pl_en[0] = 1'b1; pl_en[1] = 1'b1;
    @(negedge Clk);
    pl_en[0] = 1'b0; pl_en[1] = 1'b0;
    ref_wr(0, a, d);
    ref_wr(1, a, d);
  endtask

  // One core access: strobes rise before edge E0 and are held for 'hold' edges.
  // Sample k is taken on the falling edge after edge E0+k.
  task automatic access(input int i, input bit do_wr, input bit do_rd,
                        input logic [15:0] a, input logic [15:0] d,
                        input int hold, input string nm);
    int lat, kend;
    logic [15:0] prev, exp_data;
    lat  = do_wr ? wr_lat(i) + 1 : rd_lat(i);
    kend = (hold > lat) ? hold : lat + 1;
    prev = last_rd[i];
    exp_data = do_wr ? prev : ref_rd(i, a);
    addr[i] = a; dto[i] = d; we[i] = do_wr; oe[i] = do_rd;
    for (int k = 0; k <= kend; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (ben[i] !== (k == 0)) begin
        n_bad++;
        $display("FAIL %s bram_en k=%0d got %b want %b", nm, k, ben[i], (k == 0));
      end
      n_cmp++;
      if (rdy[i] !== (k == lat)) begin
        n_bad++;
        $display("FAIL %s Mem_Ready k=%0d got %b want %b", nm, k, rdy[i], (k == lat));
      end
      n_cmp++;
      if (dfrom[i] !== ((k >= lat) ? exp_data : prev)) begin
        n_bad++;
        $display("FAIL %s Data_from_SRAM k=%0d got %h want %h", nm, k, dfrom[i],
                 (k >= lat) ? exp_data : prev);
      end
      if (k == 0) begin
        n_cmp++;
        if (baddr[i] !== a) begin
          n_bad++;
          $display("FAIL %s bram_addr got %h want %h", nm, baddr[i], a);
        end
        n_cmp++;
        if (bwe[i] !== do_wr) begin
          n_bad++;
          $display("FAIL %s bram_we got %b want %b", nm, bwe[i], do_wr);
        end
        if (do_wr) begin
          n_cmp++;
          if (bdin[i] !== d) begin
            n_bad++;
            $display("FAIL %s bram_din got %h want %h", nm, bdin[i], d);
          end
        end
        addr[i] = 16'($urandom);
        dto[i]  = 16'($urandom);
      end else if (bwe[i] !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s bram_we k=%0d got %b want 0", nm, k, bwe[i]);
      end
      if (k == hold - 1) begin
        oe[i] = 1'b0; we[i] = 1'b0;
      end
    end
    if (do_wr) ref_wr(i, a, d);
    else last_rd[i] = exp_data;
  endtask

  task automatic test_reset_state();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({dfrom[i], rdy[i], baddr[i], ben[i], bwe[i], bdin[i]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state[%0d] got dout=%h rdy=%b addr=%h en=%b we=%b din=%h want all 0",
                 i, dfrom[i], rdy[i], baddr[i], ben[i], bwe[i], bdin[i]);
      end
    end
  endtask

  task automatic test_read();
    access(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 6, "read_beef");
  endtask

  task automatic test_write();
    access(0, 1'b1, 1'b0, 16'h0020, 16'h1234, 3, "write_1234");
    access(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 3, "readback_1234");
  endtask

  task automatic test_oe_we_both();
    access(0, 1'b1, 1'b1, 16'h0030, 16'h5A5A, 3, "both_strobes");
    access(0, 1'b0, 1'b1, 16'h0030, 16'h0000, 1, "readback_5a5a");
  endtask

  task automatic test_reset();
    addr[0] = 16'h0010; dto[0] = 16'hFFFF; oe[0] = 1'b1; we[0] = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (ben[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_accept bram_en got %b want 1", ben[0]);
    end
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({dfrom[0], rdy[0], baddr[0], ben[0], bwe[0], bdin[0]} !== '0) begin
      n_bad++;
      $display("FAIL rst_async got dout=%h rdy=%b addr=%h en=%b we=%b din=%h want all 0",
               dfrom[0], rdy[0], baddr[0], ben[0], bwe[0], bdin[0]);
    end
    n_cmp++;
    if (dfrom[1] !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_async_inst1 Data_from_SRAM got %h want 0000", dfrom[1]);
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (rdy[0] !== 1'b0 || ben[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_hold c=%0d got rdy=%b en=%b want 0/0", c, rdy[0], ben[0]);
      end
    end
    Reset = 1'b1;
    access(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 4, "rst_reread");
  endtask

  task automatic test_back_to_back();
    access(0, 1'b0, 1'b1, 16'h0001, 16'h0000, 3, "b2b_first");
    access(0, 1'b0, 1'b1, 16'h0002, 16'h0000, 3, "b2b_second");
  endtask

  task automatic test_drop_early();
    access(0, 1'b0, 1'b1, 16'h0001, 16'h0000, 1, "drop_read");
    access(0, 1'b1, 1'b0, 16'h0021, 16'hC0DE, 1, "drop_write");
    access(0, 1'b0, 1'b1, 16'h0021, 16'h0000, 2, "drop_readback");
  endtask

  task automatic test_fast_instance();
    access(1, 1'b0, 1'b1, 16'h0010, 16'h0000, 3, "fast_read");
    access(1, 1'b1, 1'b0, 16'h0022, 16'h7777, 1, "fast_write");
    access(1, 1'b0, 1'b1, 16'h0022, 16'h0000, 1, "fast_readback");
    access(1, 1'b1, 1'b1, 16'h0023, 16'h3C3C, 4, "fast_both");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int i, kind, lat;
      logic [15:0] a, d;
      i    = n % 2;
      kind = int'($urandom_range(0, 2));
      a    = 16'h0040 + 16'($urandom_range(0, 15));
      d    = 16'($urandom);
      lat  = (kind == 0) ? rd_lat(i) : wr_lat(i) + 1;
      access(i, kind != 0, kind != 1, a, d, int'($urandom_range(1, lat + 3)), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b0;
    pl_en[0] = 1'b0; pl_en[1] = 1'b0;
    pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; dto[i] = '0; oe[i] = 1'b0; we[i] = 1'b0; last_rd[i] = '0;
    end
    repeat (2) @(negedge Clk);
    test_reset_state();
    Reset = 1'b1;
    preload(16'h0010, 16'hBEEF);
    preload(16'h0001, 16'h0AAA);
    preload(16'h0002, 16'h0BBB);
    for (int j = 0; j < 16; j++) preload(16'h0040 + 16'(j), 16'($urandom));
    test_read();
    test_write();
    test_oe_we_both();
    test_reset();
    test_back_to_back();
    test_drop_early();
    test_fast_instance();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
